load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage of the RV32IM core. It sits directly downstream of the execute-stage ALU and consumes its `alu_result` as the effective address for loads and stores.
- Drives a req/gnt/rvalid data-memory port with byte enables and lane-replicated store data. Sign- or zero-extends load data.
- Non-memory results pass through as a registered one-cycle writeback. Stalls execute via `ex_ready` while a memory access is outstanding.

Parameters:
- MAX_WAIT_CYCLES, 255: cycles the unit waits for gnt, or for rvalid, before aborting the access.
- WAIT_CNT_WIDTH, 8: width of the wait counter; must satisfy 2^WAIT_CNT_WIDTH > MAX_WAIT_CYCLES.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  unit accepts an instruction this cycle; low = stall execute
- alu_operation  in  8  operation code, existing ALU_OPERATIONS_* encoding
- alu_result  in  32  ALU result / effective address
- store_data  in  32  rs2 value for stores
- rd_addr  in  5  destination register
- rd_wr_en  in  1  instruction writes rd
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data
- wb_valid  out  1  one-cycle retire pulse
- wb_rd  out  5  destination register
- wb_wr_en  out  1  register file write enable
- wb_data  out  32  writeback data
- misaligned  out  1  one-cycle pulse, misaligned access dropped
- bus_timeout  out  1  one-cycle pulse, access aborted

Behaviour:
- Reset state:
  - state = IDLE.
  - All registered outputs = 0, including `dmem_*`, `wb_*`, `misaligned` and `bus_timeout`.
  - `ex_ready` = 1 (combinational: state == IDLE).
- FSM states are IDLE, ADDR and DATA. Accept = ex_valid && ex_ready.
- Non-memory op accepted in cycle N:
  - wb_valid = 1 in N+1, with wb_data = alu_result, wb_rd = rd_addr, wb_wr_en = rd_wr_en.
  - State stays IDLE, so back-to-back accepts are allowed.
- Misalignment checks:
  - LH, LHU and SH require addr[0] = 0.
  - LW and SW require addr[1:0] = 0.
  - On violation: no memory request; misaligned = 1 and wb_valid = 1 with wb_wr_en = 0 in N+1.
- Aligned load or store accepted in N:
  - In N+1: dmem_req = 1, with dmem_we/dmem_addr/dmem_be/dmem_wdata registered; state goes to ADDR.
  - Request fields hold stable until dmem_gnt is sampled high.
- Byte enables by operation:
  - SB and byte loads: be = 1 << addr[1:0].
  - SH and half loads: be = addr[1] ? 4'b1100 : 4'b0011.
  - SW and LW: be = 4'b1111.
- Store data: SB → {4{store_data[7:0]}}; SH → {2{store_data[15:0]}}; SW → store_data.
- ADDR state, on gnt:
  - dmem_req drops the next cycle.
  - Store: wb_valid = 1 with wb_wr_en = 0 the next cycle; return to IDLE.
  - Load: enter DATA.
- DATA state, on dmem_rvalid:
  - The next cycle: wb_valid = 1, wb_wr_en = rd_wr_en, wb_data = extended load data; return to IDLE.
- Load extraction:
  - lane = dmem_rdata >> (8 * addr[1:0]).
  - LB/LBU: sign-/zero-extend lane[7:0].
  - LH/LHU: sign-/zero-extend lane[15:0].
  - LW: dmem_rdata.
  - The address offset and op are latched at accept.
- dmem_rvalid is sampled only in DATA; memory guarantees rvalid ≥ 1 cycle after gnt. rvalid in IDLE or ADDR is ignored.
- Timeout:
  - The wait counter clears on entering ADDR and on entering DATA, and increments every cycle in those states.
  - If it reaches MAX_WAIT_CYCLES without gnt (ADDR) or rvalid (DATA): dmem_req drops, bus_timeout = 1, wb_valid = 1 with wb_wr_en = 0 next cycle; return to IDLE.
- A gnt or rvalid arriving in the same cycle the counter expires wins; there is no timeout.
- `ex_ready` = 0 in ADDR and DATA; `ex_valid` is ignored there.
- Reset asserted mid-access clears `dmem_req` and the FSM immediately (asynchronous). Pending results are discarded; no wb_valid follows reset.
- wb_valid, misaligned and bus_timeout are single-cycle pulses. At most one retire occurs per accepted instruction.

Decomposition:
- The shared ISA package gains:
  - an LSU op classification helper function (is_load, is_store, size, unsigned), keyed on the ALU_OPERATIONS_* codes;
  - an lsu_state_e enum {IDLE, ADDR, DATA};
  - byte-enable constants.
- One natural sub-module: lsu_load_align (combinational rdata lane select plus sign/zero extension), reused later by any cache fill path.

Test Plan:
- ADD result 0x0000_1234, rd = 5 → wb_valid next cycle, wb_data = 0x0000_1234, no dmem_req, ex_ready stays 1.
- SB at 0x1003, data 0xAB, gnt after 2 cycles → dmem_be = 4'b1000, dmem_wdata = 0xABABABAB, dmem_addr = 0x1000, req held 3 cycles; wb_valid with wb_wr_en = 0.
- LB at 0x2001 with rdata 0x0000_8000, immediate gnt, rvalid 1 cycle later → wb_data = 0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- LW at 0x3002 → misaligned pulse, no dmem_req, wb_valid with wb_wr_en = 0 next cycle.
- LW with gnt never asserted, MAX_WAIT_CYCLES = 4 → dmem_req drops after 4 cycles, bus_timeout pulse, ex_ready returns to 1.
- rst_n low while in DATA → dmem_req = 0 and wb_valid = 0 immediately. rvalid after release is ignored; the next ADD retires normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared ISA definitions for the memory stage: operation codes,
// LSU op classification, FSM states and byte-enable constants.
package load_store_unit_pkg;

  localparam logic [7:0] ALU_OPERATIONS_ADD = 8'h00;
  localparam logic [7:0] ALU_OPERATIONS_SUB = 8'h01;
  localparam logic [7:0] ALU_OPERATIONS_AND = 8'h02;
  localparam logic [7:0] ALU_OPERATIONS_OR  = 8'h03;
  localparam logic [7:0] ALU_OPERATIONS_XOR = 8'h04;
  localparam logic [7:0] ALU_OPERATIONS_SLL = 8'h05;
  localparam logic [7:0] ALU_OPERATIONS_LB  = 8'h30;
  localparam logic [7:0] ALU_OPERATIONS_LH  = 8'h31;
  localparam logic [7:0] ALU_OPERATIONS_LW  = 8'h32;
  localparam logic [7:0] ALU_OPERATIONS_LBU = 8'h34;
  localparam logic [7:0] ALU_OPERATIONS_LHU = 8'h35;
  localparam logic [7:0] ALU_OPERATIONS_SB  = 8'h38;
  localparam logic [7:0] ALU_OPERATIONS_SH  = 8'h39;
  localparam logic [7:0] ALU_OPERATIONS_SW  = 8'h3a;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_ADDR = 2'd1,
    LSU_DATA = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    lsu_size_e size;
    logic      uns;
  } lsu_op_t;

  function automatic lsu_op_t lsu_classify(
    input logic [7:0] op
  );
    lsu_op_t c;
    c.is_load  = 1'b0;
    c.is_store = 1'b0;
    c.size     = SZ_W;
    c.uns      = 1'b0;
    case (op)
      ALU_OPERATIONS_LB: begin
        c.is_load = 1'b1; c.size = SZ_B;
      end
      ALU_OPERATIONS_LBU: begin
        c.is_load = 1'b1; c.size = SZ_B;
        c.uns = 1'b1;
      end
      ALU_OPERATIONS_LH: begin
        c.is_load = 1'b1; c.size = SZ_H;
      end
      ALU_OPERATIONS_LHU: begin
        c.is_load = 1'b1; c.size = SZ_H;
        c.uns = 1'b1;
      end
      ALU_OPERATIONS_LW: c.is_load = 1'b1;
      ALU_OPERATIONS_SB: begin
        c.is_store = 1'b1; c.size = SZ_B;
      end
      ALU_OPERATIONS_SH: begin
        c.is_store = 1'b1; c.size = SZ_H;
      end
      ALU_OPERATIONS_SW: c.is_store = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/gnt/rvalid port; master side is the LSU,
// slave side is the memory.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load data lane select with sign/zero extension; shared with
// any future cache refill path.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  lsu_size_e   size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);
  logic [31:0] lane;
  logic        sb;
  logic        sh;

  assign lane = rdata_i >> {off_i, 3'b000};
  assign sb   = ~uns_i & lane[7];
  assign sh   = ~uns_i & lane[15];

  always_comb begin
    data_o = lane;
    case (size_i)
      SZ_B:    data_o = {{24{sb}}, lane[7:0]};
      SZ_H:    data_o = {{16{sh}}, lane[15:0]};
      default: data_o = lane;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// RV32IM memory stage: drives the data-memory port for loads and
// stores and registers every result into a one-cycle writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MAX_WAIT_CYCLES = 255,
  parameter int WAIT_CNT_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [7:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  input  logic        rd_wr_en,
  load_store_unit_if.master dmem,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_wr_en,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_timeout
);
  localparam int CW = WAIT_CNT_WIDTH;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(MAX_WAIT_CYCLES - 1);

  lsu_state_e state_q, state_d;
  lsu_op_t    cls;
  lsu_size_e  size_q, size_d;
  logic [1:0] off, off_q, off_d;
  logic       uns_q, uns_d;
  logic       wr_q, wr_d;
  logic       mem, mis, accept, expire;
  logic [3:0] be_acc;
  logic [31:0] wd_acc, ld_data;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdat_q, wdat_d;
  logic [3:0]  be_q, be_d;
  logic        wbv_q, wbv_d, wbw_q, wbw_d;
  logic [4:0]  wbr_q, wbr_d;
  logic [31:0] wbd_q, wbd_d;
  logic        mis_q, mis_d, to_q, to_d;

  assign cls      = lsu_classify(alu_operation);
  assign off      = alu_result[1:0];
  assign mem      = cls.is_load | cls.is_store;
  assign ex_ready = (state_q == LSU_IDLE);
  assign accept   = ex_valid & ex_ready;
  assign expire   = (cnt_q == CNT_LAST);
  assign mis      = (cls.size == SZ_H && off[0]) ||
                    (cls.size == SZ_W && off != 2'b00);

  always_comb begin
    case (cls.size)
      SZ_B: begin
        be_acc = BE_BYTE0 << off;
        wd_acc = {4{store_data[7:0]}};
      end
      SZ_H: begin
        be_acc = off[1] ? BE_HALF_HI : BE_HALF_LO;
        wd_acc = {2{store_data[15:0]}};
      end
      default: begin
        be_acc = BE_WORD;
        wd_acc = store_data;
      end
    endcase
  end

  lsu_load_align u_align (
    .rdata_i (dmem.rdata),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    wr_d    = wr_q;
    wbv_d   = 1'b0;
    wbw_d   = 1'b0;
    wbr_d   = wbr_q;
    wbd_d   = '0;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          wbr_d = rd_addr;
          if (!mem) begin
            wbv_d = 1'b1;
            wbw_d = rd_wr_en;
            wbd_d = alu_result;
          end else if (mis) begin
            wbv_d = 1'b1;
            mis_d = 1'b1;
          end else begin
            state_d = LSU_ADDR;
            req_d   = 1'b1;
            we_d    = cls.is_store;
            addr_d  = {alu_result[31:2], 2'b00};
            be_d    = be_acc;
            wdat_d  = wd_acc;
            size_d  = cls.size;
            off_d   = off;
            uns_d   = cls.uns;
            wr_d    = rd_wr_en;
          end
        end
      end
      LSU_ADDR: begin
        // a grant in the expiring cycle still counts
        if (dmem.gnt) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (we_q) begin
            state_d = LSU_IDLE;
            wbv_d   = 1'b1;
          end else begin
            state_d = LSU_DATA;
          end
        end else if (expire) begin
          req_d   = 1'b0;
          state_d = LSU_IDLE;
          wbv_d   = 1'b1;
          to_d    = 1'b1;
        end
      end
      LSU_DATA: begin
        if (dmem.rvalid) begin
          state_d = LSU_IDLE;
          wbv_d   = 1'b1;
          wbw_d   = wr_q;
          wbd_d   = ld_data;
        end else if (expire) begin
          state_d = LSU_IDLE;
          wbv_d   = 1'b1;
          to_d    = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdat_q  <= '0;
      size_q  <= SZ_B;
      off_q   <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      wbv_q   <= 1'b0;
      wbw_q   <= 1'b0;
      wbr_q   <= '0;
      wbd_q   <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      wr_q    <= wr_d;
      wbv_q   <= wbv_d;
      wbw_q   <= wbw_d;
      wbr_q   <= wbr_d;
      wbd_q   <= wbd_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  assign dmem.req    = req_q;
  assign dmem.we     = we_q;
  assign dmem.addr   = addr_q;
  assign dmem.be     = be_q;
  assign dmem.wdata  = wdat_q;
  assign wb_valid    = wbv_q;
  assign wb_rd       = wbr_q;
  assign wb_wr_en    = wbw_q;
  assign wb_data     = wbd_q;
  assign misaligned  = mis_q;
  assign bus_timeout = to_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases, then random
// traffic against a latency-programmable memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int MAXW = 4;

  typedef struct {
    bit          mis;
    bit          to;
    bit          wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gd;
    int          rdl;
    logic [31:0] rdata;
  } req_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        ex_valid = 0;
  logic        ex_ready;
  logic [7:0]  alu_operation = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        rd_wr_en = 0;
  logic        wb_valid, wb_wr_en, misaligned, bus_timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  bit          force_rv = 0;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  req_t plan_q[$];

  load_store_unit_if dmem_bus();

  load_store_unit #(
    .MAX_WAIT_CYCLES (MAXW),
    .WAIT_CNT_WIDTH  (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .rd_addr       (rd_addr),
    .rd_wr_en      (rd_wr_en),
    .dmem          (dmem_bus),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_wr_en      (wb_wr_en),
    .wb_data       (wb_data),
    .misaligned    (misaligned),
    .bus_timeout   (bus_timeout)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, want);
    end
  endfunction

  function automatic void kind(input logic [7:0] op,
                               output bit ld, output bit st,
                               output int nb, output bit sgn);
    ld = 0; st = 0; nb = 4; sgn = 0;
    case (op)
      ALU_OPERATIONS_LB:  begin ld = 1; nb = 1; sgn = 1; end
      ALU_OPERATIONS_LBU: begin ld = 1; nb = 1; end
      ALU_OPERATIONS_LH:  begin ld = 1; nb = 2; sgn = 1; end
      ALU_OPERATIONS_LHU: begin ld = 1; nb = 2; end
      ALU_OPERATIONS_LW:  ld = 1;
      ALU_OPERATIONS_SB:  begin st = 1; nb = 1; end
      ALU_OPERATIONS_SH:  begin st = 1; nb = 2; end
      ALU_OPERATIONS_SW:  st = 1;
      default: ;
    endcase
  endfunction

  // Reference model: predict the retire and the bus request.
  task automatic issue(input logic [7:0] op,
                       input logic [31:0] a, sd,
                       input logic [4:0] rd, input bit wr,
                       input int gd, rdl,
                       input logic [31:0] rdata,
                       input bit push_exp);
    bit ld, st, sgn;
    int nb, off, bud;
    exp_t e;
    req_t r;
    logic [31:0] mask, v;
    bud = 0;
    while (!ex_ready && bud < 50) begin
      @(negedge clk);
      bud++;
    end
    if (!ex_ready) chk("ex_ready_wait", 0, 1);
    kind(op, ld, st, nb, sgn);
    off = int'(a % 4);
    e = '{mis: 0, to: 0, wr: 0, rd: rd, data: 0};
    if (!ld && !st) begin
      e.wr = wr;
      e.data = a;
    end else if (a % nb != 0) begin
      e.mis = 1;
    end else begin
      r.we = st;
      r.addr = a & 32'hFFFF_FFFC;
      r.be = '0;
      for (int i = 0; i < nb; i++) r.be[off+i] = 1'b1;
      for (int j = 0; j < 4; j++)
        r.wdata[8*j +: 8] = sd[8*(j%nb) +: 8];
      r.gd = gd; r.rdl = rdl; r.rdata = rdata;
      plan_q.push_back(r);
      if (gd >= MAXW || (ld && rdl >= MAXW)) begin
        e.to = 1;
      end else if (ld) begin
        mask = (nb == 4) ? 32'hFFFF_FFFF
                         : ((32'd1 << (8*nb)) - 1);
        v = (rdata >> (8*off)) & mask;
        if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
        e.wr = wr;
        e.data = v;
      end
    end
    if (push_exp) exp_q.push_back(e);
    ex_valid = 1;
    alu_operation = op;
    alu_result = a;
    store_data = sd;
    rd_addr = rd;
    rd_wr_en = wr;
    @(negedge clk);
    ex_valid = 0;
    alu_operation = 8'($urandom);
  endtask

  task automatic count_req(input int want, input string name);
    int n;
    n = 0;
    while (dmem_bus.req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, want);
  endtask

  // Memory model: grant/rvalid latencies come from the plan queue.
  initial begin : mem_model
    int req_cnt, data_cnt;
    bit in_data;
    req_t cur;
    req_cnt = 0; data_cnt = 0; in_data = 0;
    dmem_bus.gnt = 0;
    dmem_bus.rvalid = 0;
    dmem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      dmem_bus.gnt = 0;
      dmem_bus.rvalid = force_rv;
      dmem_bus.rdata = $urandom;
      if (!rst_n) begin
        req_cnt = 0; in_data = 0;
      end else if (in_data) begin
        if (data_cnt == cur.rdl) begin
          dmem_bus.rvalid = 1;
          dmem_bus.rdata = cur.rdata;
          in_data = 0;
        end else begin
          data_cnt++;
          if (data_cnt >= MAXW) in_data = 0;
        end
      end else if (dmem_bus.req) begin
        if (req_cnt == 0) begin
          if (plan_q.size() == 0) begin
            chk("unexpected_req", 1, 0);
            cur = '{0, 0, 0, 0, 99, 99, 0};
          end else begin
            cur = plan_q.pop_front();
          end
        end
        chk("req_we", 32'(dmem_bus.we), 32'(cur.we));
        chk("req_addr", dmem_bus.addr, cur.addr);
        chk("req_be", 32'(dmem_bus.be), 32'(cur.be));
        if (cur.we) chk("req_wdata", dmem_bus.wdata, cur.wdata);
        if (req_cnt == cur.gd) begin
          dmem_bus.gnt = 1;
          req_cnt = 0;
          in_data = !cur.we;
          data_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wb_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_wb", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("wb_wr_en", 32'(wb_wr_en), 32'(e.wr));
            chk("misaligned", 32'(misaligned), 32'(e.mis));
            chk("bus_timeout", 32'(bus_timeout), 32'(e.to));
            if (e.wr) begin
              chk("wb_rd", 32'(wb_rd), 32'(e.rd));
              chk("wb_data", wb_data, e.data);
            end
          end
        end else if (misaligned || bus_timeout) begin
          chk("pulse_without_wb", 1, 0);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] mem_ops[8];
    logic [7:0] alu_ops[6];
    logic [7:0] op;
    logic [31:0] a;
    int bud;
    mem_ops = '{ALU_OPERATIONS_LB, ALU_OPERATIONS_LBU,
                ALU_OPERATIONS_LH, ALU_OPERATIONS_LHU,
                ALU_OPERATIONS_LW, ALU_OPERATIONS_SB,
                ALU_OPERATIONS_SH, ALU_OPERATIONS_SW};
    alu_ops = '{ALU_OPERATIONS_ADD, ALU_OPERATIONS_SUB,
                ALU_OPERATIONS_AND, ALU_OPERATIONS_OR,
                ALU_OPERATIONS_XOR, ALU_OPERATIONS_SLL};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ex_ready", 32'(ex_ready), 1);
    chk("rst_req", 32'(dmem_bus.req), 0);
    chk("rst_we", 32'(dmem_bus.we), 0);
    chk("rst_addr", dmem_bus.addr, 0);
    chk("rst_be", 32'(dmem_bus.be), 0);
    chk("rst_wdata", dmem_bus.wdata, 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mis", 32'(misaligned), 0);
    chk("rst_to", 32'(bus_timeout), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    issue(ALU_OPERATIONS_ADD, 32'h1234, 0, 5, 1, 0, 0, 0, 1);
    chk("add_ex_ready", 32'(ex_ready), 1);
    chk("add_no_req", 32'(dmem_bus.req), 0);

    issue(ALU_OPERATIONS_SB, 32'h1003, 32'hAB, 1, 1,
          2, 0, 0, 1);
    chk("sb_be", 32'(dmem_bus.be), 32'b1000);
    chk("sb_wdata", dmem_bus.wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_bus.addr, 32'h1000);
    count_req(3, "sb_req_cycles");

    issue(ALU_OPERATIONS_LB, 32'h2001, 0, 7, 1,
          0, 0, 32'h0000_8000, 1);
    issue(ALU_OPERATIONS_LBU, 32'h2001, 0, 8, 1,
          0, 0, 32'h0000_8000, 1);

    issue(ALU_OPERATIONS_LW, 32'h3002, 0, 9, 1, 0, 0, 0, 1);
    chk("mis_no_req", 32'(dmem_bus.req), 0);

    issue(ALU_OPERATIONS_LW, 32'h5000, 0, 10, 1,
          255, 0, 0, 1);
    chk("to_stall", 32'(ex_ready), 0);
    count_req(MAXW, "to_req_cycles");
    chk("to_ready_back", 32'(ex_ready), 1);

    issue(ALU_OPERATIONS_LW, 32'h4000, 0, 11, 1,
          0, 255, 0, 0);
    @(negedge clk);
    chk("data_stall", 32'(ex_ready), 0);
    #2 rst_n = 0;
    #1;
    chk("arst_req", 32'(dmem_bus.req), 0);
    chk("arst_wb_valid", 32'(wb_valid), 0);
    chk("arst_ex_ready", 32'(ex_ready), 1);
    @(negedge clk);
    #3 rst_n = 1;
    @(negedge clk);
    force_rv = 1;
    repeat (2) @(negedge clk);
    force_rv = 0;
    issue(ALU_OPERATIONS_ADD, 32'hCAFE, 0, 12, 1, 0, 0, 0, 1);

    for (int k = 0; k < 300; k++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = (a & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 9) < 4)
        op = alu_ops[$urandom_range(0, 5)];
      else
        op = mem_ops[$urandom_range(0, 7)];
      issue(op, a, $urandom, 5'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0) ? 255
                                        : $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0) ? 255
                                        : $urandom_range(0, 3),
            $urandom, 1);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    bud = 0;
    while (exp_q.size() != 0 && bud < 200) begin
      @(negedge clk);
      bud++;
    end
    repeat (2) @(negedge clk);
    chk("drain_exp", 32'(exp_q.size()), 0);
    chk("drain_plan", 32'(plan_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
